// File: rtl/clkgate_pwrdn_ctrl.sv
// Idle-driven clock gating for a gated domain: registered enable, negedge enable latch and AND gate.
// Gates after an idle interval; on wake, clk_gated runs for WAKE_CYCLES before acking wake requesters.
module clkgate_pwrdn_ctrl #(
  parameter int NREQ        = 4,
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             pd_enable,
  input  logic [NREQ-1:0]  busy,
  input  logic [NREQ-1:0]  wake_req,
  input  logic             cnt_clr,
  output logic             clk_gated,
  output logic             gate_en,
  output logic             gated,
  output logic [NREQ-1:0]  wake_ack,
  output logic [CNT_W-1:0] gated_cycles
);

  typedef enum logic [1:0] {RUN, IDLE_WAIT, GATED, WAKE} state_t;

  localparam logic [7:0] IDLE_LOAD = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [7:0]        idle_cnt_q, idle_cnt_d;
  logic [7:0]        wake_cnt_q, wake_cnt_d;
  logic              en_r_q, en_r_d;
  logic              gated_q, gated_d;
  logic              en_lat_q;
  logic [NREQ-1:0]   wake_pend_q, wake_pend_d;
  logic [NREQ-1:0]   wake_ack_q, wake_ack_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              activity;

  assign activity = !pd_enable || (|busy) || (|wake_req);

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    en_r_d      = en_r_q;
    gated_d     = gated_q;
    wake_pend_d = wake_pend_q;
    wake_ack_d  = '0;
    case (state_q)
      RUN: begin
        if (!activity) begin
          state_d    = IDLE_WAIT;
          idle_cnt_d = IDLE_LOAD;
        end
      end
      IDLE_WAIT: begin
        // Any activity aborts, even on the cycle the countdown would expire.
        if (activity) begin
          state_d = RUN;
        end else if (idle_cnt_q == 8'd0) begin
          state_d = GATED;
          en_r_d  = 1'b0;
          gated_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q - 8'd1;
        end
      end
      GATED: begin
        if (activity) begin
          state_d     = WAKE;
          en_r_d      = 1'b1;
          gated_d     = 1'b0;
          wake_cnt_d  = WAKE_LOAD;
          wake_pend_d = wake_pend_q | wake_req;
        end
      end
      WAKE: begin
        // Requesters seen on any WAKE cycle, including the last, join the ack.
        if (wake_cnt_q == 8'd0) begin
          state_d     = RUN;
          wake_ack_d  = wake_pend_q | wake_req;
          wake_pend_d = '0;
        end else begin
          wake_cnt_d  = wake_cnt_q - 8'd1;
          wake_pend_d = wake_pend_q | wake_req;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (!en_lat_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= RUN;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      en_r_q      <= 1'b1;
      gated_q     <= 1'b0;
      wake_pend_q <= '0;
      wake_ack_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      en_r_q      <= en_r_d;
      gated_q     <= gated_d;
      wake_pend_q <= wake_pend_d;
      wake_ack_q  <= wake_ack_d;
      cnt_q       <= cnt_d;
    end
  end

  // Enable only changes while clk is low, so the AND below cannot glitch.
  always_ff @(negedge clk or negedge reset_l) begin
    if (!reset_l) begin
      en_lat_q <= 1'b1;
    end else begin
      en_lat_q <= en_r_q;
    end
  end

  assign clk_gated    = clk & en_lat_q;
  assign gate_en      = en_r_q;
  assign gated        = gated_q;
  assign wake_ack     = wake_ack_q;
  assign gated_cycles = cnt_q;

endmodule

// File: tb/tb_clkgate_pwrdn_ctrl.sv
// Self-checking bench: hand-derived vector table, multi-cycle corner sequences and random stimulus vs a model.
module tb_clkgate_pwrdn_ctrl;

  localparam int IDLE_CYCLES = 4;
  localparam int WAKE_CYCLES = 2;

  logic        clk;
  logic        reset_l;
  logic        pd_enable;
  logic [3:0]  busy;
  logic [3:0]  wake_req;
  logic        cnt_clr;
  logic        clk_gated, gate_en, gated;
  logic [3:0]  wake_ack;
  logic [15:0] gated_cycles;
  logic        clk_gated4, gate_en4, gated4;
  logic [3:0]  wake_ack4;
  logic [3:0]  gated_cycles4;

  clkgate_pwrdn_ctrl #(.NREQ(4), .IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .CNT_W(16)) dut (
    .clk(clk), .reset_l(reset_l), .pd_enable(pd_enable), .busy(busy), .wake_req(wake_req),
    .cnt_clr(cnt_clr), .clk_gated(clk_gated), .gate_en(gate_en), .gated(gated),
    .wake_ack(wake_ack), .gated_cycles(gated_cycles));

  clkgate_pwrdn_ctrl #(.NREQ(4), .IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .CNT_W(4)) dut4 (
    .clk(clk), .reset_l(reset_l), .pd_enable(pd_enable), .busy(busy), .wake_req(wake_req),
    .cnt_clr(cnt_clr), .clk_gated(clk_gated4), .gate_en(gate_en4), .gated(gated4),
    .wake_ack(wake_ack4), .gated_cycles(gated_cycles4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int gclk_cnt = 0;
  always @(posedge clk_gated) gclk_cnt <= gclk_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counts consecutive idle samples, a wake countdown and suppressed edges.
  bit          m_gated;
  int          m_wake_left;
  int          m_streak;
  logic [3:0]  m_pend, m_ack;
  int unsigned m_cnt;
  bit          m_lat, m_lat_prev;
  int          exp_gclk;

  typedef struct {
    logic       pe;
    logic [3:0] b;
    logic [3:0] w;
    logic       clr;
    logic       exp_gate_en;
    logic       exp_gated;
    logic [3:0] exp_ack;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_gated = 0; m_wake_left = -1; m_streak = 0; m_pend = '0; m_ack = '0;
    m_cnt = 0; m_lat = 1; m_lat_prev = 1;
  endtask

  task automatic model_edge();
    bit idle;
    idle = pd_enable && (busy == 4'h0) && (wake_req == 4'h0);
    m_ack = '0;
    m_lat_prev = m_lat;
    if (cnt_clr) m_cnt = 0;
    else if (!m_lat) m_cnt++;
    if (m_lat) exp_gclk++;
    if (m_wake_left >= 0) begin
      m_pend |= wake_req;
      if (m_wake_left == 0) begin
        m_ack = m_pend; m_pend = '0; m_wake_left = -1; m_streak = 0;
      end else begin
        m_wake_left--;
      end
    end else if (m_gated) begin
      if (!idle) begin
        m_gated = 0; m_wake_left = WAKE_CYCLES - 1; m_pend = wake_req;
      end
    end else if (idle) begin
      m_streak++;
      if (m_streak > IDLE_CYCLES) begin
        m_gated = 1; m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    m_lat = !m_gated;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gate_en", gate_en, !m_gated);
    chk("gated", gated, m_gated);
    chk("wake_ack", wake_ack, m_ack);
    chk("gated_cycles", gated_cycles, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("gated_cycles_w4", gated_cycles4, (m_cnt > 15) ? 15 : m_cnt);
    chk("gate_en_w4", gate_en4, !m_gated);
    chk("clk_gated_hi", clk_gated, m_lat_prev);
    chk("clk_gated_edges", gclk_cnt, exp_gclk);
  endtask

  // Asserts reset mid-low-phase, holds it three cycles, releases mid-low-phase.
  task automatic do_reset();
    int g0;
    @(negedge clk);
    #2;
    reset_l = 1'b0;
    model_reset();
    #1;
    chk("rst_gate_en", gate_en, 1);
    chk("rst_gated", gated, 0);
    chk("rst_wake_ack", wake_ack, 0);
    chk("rst_gated_cycles", gated_cycles, 0);
    g0 = gclk_cnt;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_clk_gated_hi", clk_gated, 1);
      @(negedge clk); #1;
      chk("rst_clk_gated_lo", clk_gated, 0);
    end
    chk("rst_clk_gated_edges", gclk_cnt - g0, 3);
    chk("rst_gated_hold", gated, 0);
    #1;
    reset_l = 1'b1;
    exp_gclk = gclk_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_l = 1'b0; pd_enable = 1'b0; busy = '0; wake_req = '0; cnt_clr = 1'b0;
    model_reset();
    exp_gclk = 0;

    // Gate, wake with two requesters, then an abort at idle_cnt==1 and a pd_enable wake.
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[1]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[2]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[3]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[4]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0};
    tbl[5]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0};
    tbl[6]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0};
    tbl[7]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0};
    tbl[8]  = '{1'b1, 4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[9]  = '{1'b1, 4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[10] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'hA};
    tbl[11] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[12] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[13] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[14] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[15] = '{1'b1, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[16] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[17] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[18] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[19] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[20] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0};
    tbl[21] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[22] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[23] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[24] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};

    do_reset();

    for (int i = 0; i < 25; i++) begin
      pd_enable = tbl[i].pe; busy = tbl[i].b; wake_req = tbl[i].w; cnt_clr = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_gate_en", i), gate_en, tbl[i].exp_gate_en);
      chk($sformatf("tbl%0d_gated", i), gated, tbl[i].exp_gated);
      chk($sformatf("tbl%0d_wake_ack", i), wake_ack, tbl[i].exp_ack);
    end
    pd_enable = 1'b0; busy = '0; wake_req = '0;

    // Counter: clear, gate for exactly 10 suppressed edges, clear again, then saturate the 4-bit copy.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("cnt_after_clr", gated_cycles, 0);
    pd_enable = 1'b1;
    repeat (5) step();
    chk("cnt_gated_entered", gated, 1);
    repeat (9) step();
    busy = 4'h4; step(); busy = '0;
    chk("cnt_10", gated_cycles, 10);
    chk("cnt_10_w4", gated_cycles4, 10);
    pd_enable = 1'b0;
    repeat (3) step();
    chk("cnt_kept_after_wake", gated_cycles, 10);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("cnt_clr_0", gated_cycles, 0);
    pd_enable = 1'b1;
    repeat (24) step();
    pd_enable = 1'b0; step();
    chk("cnt_20", gated_cycles, 20);
    chk("cnt_sat_w4", gated_cycles4, 15);
    repeat (3) step();

    // Reset while gated; afterwards pd_enable=0 must keep the clock running.
    pd_enable = 1'b1;
    repeat (8) step();
    chk("pre_rst_gated", gated, 1);
    pd_enable = 1'b0;
    do_reset();
    repeat (30) step();
    chk("no_gate_pd0", gate_en, 1);
    chk("no_count_pd0", gated_cycles, 0);

    // Reset during WAKE with a pending request: the request is dropped, never acked.
    pd_enable = 1'b1;
    repeat (5) step();
    wake_req = 4'h4; step(); wake_req = '0;
    do_reset();
    pd_enable = 1'b0;
    repeat (6) step();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      pd_enable = ($urandom_range(0, 19) != 0);
      busy      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      wake_req  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      cnt_clr   = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
